// File: rtl/gb_ppu_common_pkg.sv
// Shared PPU types and timing constants.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package gb_ppu_common_pkg;

  localparam int unsigned PPU_DOTS_PER_LINE = 456;
  localparam int unsigned PPU_OAM_DOTS      = 80;
  localparam int unsigned PPU_MAX_DRAW_DOTS = 289;
  localparam int unsigned PPU_VISIBLE_LINES = 144;
  localparam int unsigned PPU_TOTAL_LINES   = 154;

  // Encoding matches the STAT mode field.
  typedef enum logic [1:0] {
    HBLANK     = 2'd0,
    VBLANK     = 2'd1,
    OAM_SCAN   = 2'd2,
    DRAW_PIXEL = 2'd3
  } ppu_mode_state_t;

  typedef struct packed {
    logic lcd_ppu_enable;
    logic win_tile_map;
    logic win_enable;
    logic bg_win_tile_data;
    logic bg_tile_map;
    logic obj_size;
    logic obj_enable;
    logic bg_win_enable;
  } lcd_control_t;

  typedef struct packed {
    logic lyc;
    logic mode2;
    logic mode1;
    logic mode0;
  } stat_irq_en_t;

endpackage

// File: rtl/gb_ppu_stat_irq.sv
// STAT interrupt line: ORs the enabled sources and pulses on its rising edge.
// Latency: pulse is registered alongside the mode/lyc_eq values it is built from.
// Backpressure: none; history is cleared while the LCD is off.
module gb_ppu_stat_irq
  import gb_ppu_common_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lcd_on_i,
  input  stat_irq_en_t    en_i,
  input  logic            lyc_eq_i,   // value lyc_eq register loads this cycle
  input  ppu_mode_state_t mode_i,     // value mode register loads this cycle
  output logic            stat_irq_o
);

  logic line_d;
  logic line_q;
  logic irq_q;

  // Combine the four STAT sources from the next-state values.
  always_comb begin
    line_d = (en_i.lyc   & lyc_eq_i)
           | (en_i.mode2 & (mode_i == OAM_SCAN))
           | (en_i.mode1 & (mode_i == VBLANK))
           | (en_i.mode0 & (mode_i == HBLANK));
  end

  // Hold the line history and register the 0->1 edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else if (!lcd_on_i) begin
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      line_q <= line_d;
      irq_q  <= line_d & ~line_q;
    end
  end

  assign stat_irq_o = irq_q;

endmodule

// File: rtl/gb_ppu_mode_sequencer.sv
// PPU master timing: dot/line counters, mode FSM, draw watchdog and interrupts.
// Latency: all outputs registered; mode, ly and dot always describe the same dot.
// Backpressure: none; free-running one dot per cycle while lcd_ppu_enable is set.
module gb_ppu_mode_sequencer
  import gb_ppu_common_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE = PPU_DOTS_PER_LINE,
  parameter int unsigned OAM_DOTS      = PPU_OAM_DOTS,
  parameter int unsigned MAX_DRAW_DOTS = PPU_MAX_DRAW_DOTS,
  parameter int unsigned VISIBLE_LINES = PPU_VISIBLE_LINES,
  parameter int unsigned TOTAL_LINES   = PPU_TOTAL_LINES
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] lcdc_i,
  input  logic [3:0] stat_irq_en_i,
  input  logic [7:0] lyc_i,
  input  logic       draw_done_i,
  output logic [1:0] mode_o,
  output logic [7:0] ly_o,
  output logic [8:0] dot_o,
  output logic       lyc_eq_o,
  output logic       oam_scan_start_o,
  output logic       draw_start_o,
  output logic       vblank_irq_o,
  output logic       stat_irq_o,
  output logic       draw_timeout_o
);

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_DRAW = 9'(OAM_DOTS);
  // Mode 3 always starts at DOT_DRAW, so the watchdog reduces to a fixed dot:
  // the last of MAX_DRAW_DOTS dots spent in DRAW_PIXEL.
  localparam logic [8:0] DOT_WDOG = 9'(OAM_DOTS + MAX_DRAW_DOTS - 1);
  localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] LY_VBL   = 8'(VISIBLE_LINES);

  lcd_control_t    lcdc;
  stat_irq_en_t    stat_en;
  logic            lcd_on;
  logic            unused_lcdc;

  logic            run_q, run_d;
  logic [8:0]      dot_q, dot_d;
  logic [7:0]      ly_q, ly_d;
  ppu_mode_state_t mode_q, mode_d;
  logic            lyc_eq_q, lyc_eq_d;
  logic            oam_start_q, oam_start_d;
  logic            draw_start_q, draw_start_d;
  logic            vblank_irq_q, vblank_irq_d;
  logic            draw_timeout_q, draw_timeout_d;

  assign lcdc        = lcd_control_t'(lcdc_i);
  assign stat_en     = stat_irq_en_t'(stat_irq_en_i);
  assign lcd_on      = lcdc.lcd_ppu_enable;
  assign unused_lcdc = ^lcdc;

  // Next-state: counters, mode transitions, entry pulses and watchdog.
  always_comb begin
    run_d          = lcd_on;
    dot_d          = dot_q;
    ly_d           = ly_q;
    mode_d         = mode_q;
    lyc_eq_d       = lcd_on & (ly_q == lyc_i);
    oam_start_d    = 1'b0;
    draw_start_d   = 1'b0;
    vblank_irq_d   = 1'b0;
    draw_timeout_d = draw_timeout_q;

    if (!lcd_on) begin
      dot_d  = '0;
      ly_d   = '0;
      mode_d = HBLANK;
    end else if (!run_q) begin
      // First cycle after enable: counters are already zero from the off state.
      dot_d       = '0;
      ly_d        = '0;
      mode_d      = OAM_SCAN;
      oam_start_d = 1'b1;
    end else begin
      if (dot_q == DOT_LAST) begin
        dot_d = '0;
        ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
      end

      if (ly_d >= LY_VBL) begin
        mode_d       = VBLANK;
        vblank_irq_d = (ly_d == LY_VBL) && (dot_d == 9'd0);
      end else if (dot_d == 9'd0) begin
        mode_d      = OAM_SCAN;
        oam_start_d = 1'b1;
      end else if (dot_d == DOT_DRAW) begin
        mode_d       = DRAW_PIXEL;
        draw_start_d = 1'b1;
      end else if (mode_q == DRAW_PIXEL) begin
        if (draw_done_i) begin
          mode_d = HBLANK;
        end else if (dot_q == DOT_WDOG) begin
          mode_d         = HBLANK;
          draw_timeout_d = 1'b1;
        end
      end
    end
  end

  // State registers; draw_timeout survives LCD-off and only clears on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q          <= 1'b0;
      dot_q          <= '0;
      ly_q           <= '0;
      mode_q         <= HBLANK;
      lyc_eq_q       <= 1'b0;
      oam_start_q    <= 1'b0;
      draw_start_q   <= 1'b0;
      vblank_irq_q   <= 1'b0;
      draw_timeout_q <= 1'b0;
    end else begin
      run_q          <= run_d;
      dot_q          <= dot_d;
      ly_q           <= ly_d;
      mode_q         <= mode_d;
      lyc_eq_q       <= lyc_eq_d;
      oam_start_q    <= oam_start_d;
      draw_start_q   <= draw_start_d;
      vblank_irq_q   <= vblank_irq_d;
      draw_timeout_q <= draw_timeout_d;
    end
  end

  gb_ppu_stat_irq u_stat_irq (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .lcd_on_i   (lcd_on),
    .en_i       (stat_en),
    .lyc_eq_i   (lyc_eq_d),
    .mode_i     (mode_d),
    .stat_irq_o (stat_irq_o)
  );

  assign mode_o           = mode_q;
  assign ly_o             = ly_q;
  assign dot_o            = dot_q;
  assign lyc_eq_o         = lyc_eq_q;
  assign oam_scan_start_o = oam_start_q;
  assign draw_start_o     = draw_start_q;
  assign vblank_irq_o     = vblank_irq_q;
  assign draw_timeout_o   = draw_timeout_q;

endmodule
